// File: rtl/mem_rsp_pkg.sv
// -----------------------------------------------------------------------------
// mem_rsp_pkg
// Shared definitions for the fixed-latency memory responder: the FSM state
// type, the request-type encodings and the latency-counter width/load helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_rsp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int CNT_W = 4;

    // Value loaded into the down-counter on acceptance. The accept cycle itself
    // counts as the first stall cycle, hence LATENCY-1.
    function automatic logic [CNT_W-1:0] latency_load(input int latency);
        return (latency > 0) ? CNT_W'(latency - 1) : '0;
    endfunction

endpackage

// File: rtl/mem_rsp_lat_if.sv
// -----------------------------------------------------------------------------
// mem_rsp_lat_if
// Request/response bus between an initiator and the memory responder.
//   mem_val   initiator -> responder  request present (held while mem_wait=1)
//   mem_type  initiator -> responder  0 = read, 1 = write
//   mem_addr  initiator -> responder  byte address
//   mem_wdata initiator -> responder  write data
//   mem_wait  responder -> initiator  stall; completion when val=1 and wait=0
//   mem_rdata responder -> initiator  read data, nonzero only on read completion
// -----------------------------------------------------------------------------
interface mem_rsp_lat_if;

    logic        mem_val;
    logic        mem_wait;
    logic        mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_val, mem_type, mem_addr, mem_wdata,
        input  mem_wait, mem_rdata
    );

    modport slave (
        input  mem_val, mem_type, mem_addr, mem_wdata,
        output mem_wait, mem_rdata
    );

endinterface

// File: rtl/mem_rsp_ram.sv
// -----------------------------------------------------------------------------
// mem_rsp_ram
// NWORDS x 32 storage with one combinational read port and one synchronous
// write port sharing a single word address.
//   clk    clock; writes commit on the rising edge
//   we     write enable
//   addr   word index (read and write)
//   wdata  write data
//   rdata  combinational read of mem[addr]
// -----------------------------------------------------------------------------
module mem_rsp_ram #(
    parameter int NWORDS = 256,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [NWORDS];

    // NOTE: storage is deliberately not reset; contents survive rst and a
    // reset on a RAM array would stop it mapping to a memory macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_rsp_lat.sv
// -----------------------------------------------------------------------------
// mem_rsp_lat
// Memory responder that completes every request exactly LATENCY cycles after
// it is first presented (LATENCY=0 completes in the same cycle).
//   clk  clock, rising-edge
//   rst  synchronous active-high reset; aborts an in-flight request
//   bus  mem_rsp_lat_if.slave request/response bus
// Parameters: LATENCY (0..15), NWORDS (power of two, >= 4).
// -----------------------------------------------------------------------------
module mem_rsp_lat
    import mem_rsp_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int NWORDS  = 256
) (
    input  logic          clk,
    input  logic          rst,
    mem_rsp_lat_if.slave  bus
);

    localparam int AW = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = latency_load(LATENCY);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("mem_rsp_lat: LATENCY must be in 0..15");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wait_c;
    logic             complete;
    logic             do_write;
    logic [AW-1:0]    index;
    logic [31:0]      ram_rdata;

    // Byte offset and address bits above the array are ignored, so addresses
    // wrap modulo 4*NWORDS.
    assign index = bus.mem_addr[AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};

    // Stall and completion are combinational on the current request so that a
    // request presented in cycle t completes in exactly cycle t+LATENCY.
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        wait_c   = 1'b0;
        complete = 1'b0;
        if (!rst && bus.mem_val) begin
            unique case (state)
                IDLE: begin
                    if (LATENCY == 0) complete = 1'b1;
                    else              wait_c   = 1'b1;
                end
                WAIT: begin
                    if (cnt == '0) complete = 1'b1;
                    else           wait_c   = 1'b1;
                end
            endcase
        end
    end

    assign do_write      = complete && (bus.mem_type == MEM_WRITE);
    assign bus.mem_wait  = wait_c;
    assign bus.mem_rdata = (complete && bus.mem_type == MEM_READ) ? ram_rdata : '0;

    // A completion in WAIT always returns to IDLE, so a back-to-back request
    // is only accepted (and starts counting) in the following cycle. Dropping
    // mem_val while waiting abandons the request.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.mem_val && LATENCY != 0) begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (!bus.mem_val || cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    mem_rsp_ram #(
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (do_write),
        .addr  (index),
        .wdata (bus.mem_wdata),
        .rdata (ram_rdata)
    );

endmodule
